sloth_prog_sequencer: RTL

//  Sequential interpreter for evolved 4-register programs (r0..r3, 16-bit, ops ^= |= &= !).

---
 rtl/sloth_seq_pkg.sv | 38 +++
 rtl/sloth_prog_sequencer_if.sv | 75 +++++++
 rtl/sloth_seq_alu.sv | 25 ++
 rtl/sloth_prog_sequencer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/sloth_seq_pkg.sv
// Shared types for the sloth program sequencer: opcodes, source selects,
// instruction layout and FSM states.
package sloth_seq_pkg;

  localparam int INSTR_W = 7;

  typedef enum logic [1:0] {
    OP_XOR,
    OP_OR,
    OP_AND,
    OP_NOT
  } op_e;

  typedef enum logic [2:0] {
    SRC_R0,
    SRC_R1,
    SRC_R2,
    SRC_R3,
    SRC_A0,
    SRC_A1,
    SRC_B0,
    SRC_B1
  } src_e;

  typedef struct packed {
    op_e        op;
    logic [1:0] dst;
    src_e       src;
  } instr_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEED,
    S_EXEC,
    S_FIN
  } state_e;

endpackage

// File: rtl/sloth_prog_sequencer_if.sv
// Control/data bundle of the sloth program sequencer.
// SLOTH_SEQ_ABORT_EN adds the abort/aborted pair.
interface sloth_prog_sequencer_if #(
  parameter int W  = 16,
  parameter int AW = 6
);

  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [6:0]    prog_wdata;
  logic [AW:0]   prog_len;
  logic          start;
  logic [W-1:0]  a1;
  logic [W-1:0]  a0;
  logic [W-1:0]  b1;
  logic [W-1:0]  b0;
  logic          busy;
  logic          done;
  logic [W-1:0]  y3;
  logic [W-1:0]  y2;
  logic [W-1:0]  y1;
  logic [W-1:0]  y0;
  logic          prog_err;
`ifdef SLOTH_SEQ_ABORT_EN
  logic          abort;
  logic          aborted;
`endif

  modport master (
`ifdef SLOTH_SEQ_ABORT_EN
    output abort,
    input  aborted,
`endif
    output prog_we,
    output prog_addr,
    output prog_wdata,
    output prog_len,
    output start,
    output a1,
    output a0,
    output b1,
    output b0,
    input  busy,
    input  done,
    input  y3,
    input  y2,
    input  y1,
    input  y0,
    input  prog_err
  );

  modport slave (
`ifdef SLOTH_SEQ_ABORT_EN
    input  abort,
    output aborted,
`endif
    input  prog_we,
    input  prog_addr,
    input  prog_wdata,
    input  prog_len,
    input  start,
    input  a1,
    input  a0,
    input  b1,
    input  b0,
    output busy,
    output done,
    output y3,
    output y2,
    output y1,
    output y0,
    output prog_err
  );

endinterface

// File: rtl/sloth_seq_alu.sv
// Combinational instruction ALU: dst op src -> new dst value.
module sloth_seq_alu
  import sloth_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  op_e          op_i,
  input  logic [W-1:0] dst_i,
  input  logic [W-1:0] src_i,
  output logic [W-1:0] res_o
);

  always_comb begin
    res_o = '0;
    unique case (op_i)
      OP_XOR: res_o = dst_i ^ src_i;
      OP_OR:  res_o = dst_i | src_i;
      OP_AND: res_o = dst_i & src_i;
      // logical not, zero-extended to full width
      OP_NOT: res_o = {{(W-1){1'b0}}, (src_i == '0)};
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/sloth_prog_sequencer.sv
// Sequential interpreter for 4-register evolved programs.
// Optional abort support under SLOTH_SEQ_ABORT_EN.
module sloth_prog_sequencer
  import sloth_seq_pkg::*;
#(
  parameter int W          = 16,
  parameter int PROG_DEPTH = 64,
  parameter int AW         = $clog2(PROG_DEPTH)
) (
  input logic                   clk,
  input logic                   rst,
  sloth_prog_sequencer_if.slave bus
);

  state_e              state_q, state_d;
  logic [AW-1:0]       pc_q, pc_d;
  logic [AW:0]         len_q, len_d;
  logic [3:0][W-1:0]   cap_q, cap_d;
  logic [3:0][W-1:0]   r_q, r_d;
  logic [3:0][W-1:0]   y_q, y_d;
  logic                err_q, err_d;
`ifdef SLOTH_SEQ_ABORT_EN
  logic                aborted_q, aborted_d;
`endif

  instr_t              ram [PROG_DEPTH];
  instr_t              ins;
  logic [W-1:0]        src_val;
  logic [W-1:0]        alu_res;
  logic [AW:0]         len_in;
  logic                busy;
  logic                last;

  assign busy = (state_q == S_SEED) || (state_q == S_EXEC);
  assign ins  = ram[pc_q];
  assign last = ({1'b0, pc_q} == (len_q - 1'b1));

  assign len_in = (bus.prog_len > (AW+1)'(PROG_DEPTH))
                ? (AW+1)'(PROG_DEPTH) : bus.prog_len;

  // src[2] selects the captured operands, else the live registers
  assign src_val = ins.src[2] ? cap_q[ins.src[1:0]]
                              : r_q[ins.src[1:0]];

  sloth_seq_alu #(.W(W)) u_alu (
    .op_i  (ins.op),
    .dst_i (r_q[ins.dst]),
    .src_i (src_val),
    .res_o (alu_res)
  );

  // Program RAM: writes dropped while an evaluation is running
  always_ff @(posedge clk) begin
    if (bus.prog_we && !busy) begin
      ram[bus.prog_addr] <= instr_t'(bus.prog_wdata);
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    cap_d   = cap_q;
    r_d     = r_q;
    y_d     = y_q;
    err_d   = err_q | (bus.prog_we & busy);
`ifdef SLOTH_SEQ_ABORT_EN
    aborted_d = aborted_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cap_d   = {bus.b1, bus.b0, bus.a1, bus.a0};
          len_d   = len_in;
          state_d = S_SEED;
`ifdef SLOTH_SEQ_ABORT_EN
          aborted_d = 1'b0;
`endif
        end
      end
      S_SEED: begin
        r_d     = cap_q;
        pc_d    = '0;
        state_d = (len_q == '0) ? S_FIN : S_EXEC;
      end
      S_EXEC: begin
        r_d[ins.dst] = alu_res;
        pc_d         = pc_q + 1'b1;
        if (last) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef SLOTH_SEQ_ABORT_EN
    // abort freezes the register file at its current partial state
    if (bus.abort && busy) begin
      state_d   = S_FIN;
      aborted_d = 1'b1;
      if (state_q == S_EXEC) r_d = r_q;
    end
`endif
    // publish results on entry to FIN so y* is valid with done
    if (state_d == S_FIN && state_q != S_FIN) y_d = r_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      cap_q   <= '0;
      r_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      cap_q   <= cap_d;
      r_q     <= r_d;
      y_q     <= y_d;
      err_q   <= err_d;
    end
  end

`ifdef SLOTH_SEQ_ABORT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) aborted_q <= 1'b0;
    else     aborted_q <= aborted_d;
  end

  assign bus.aborted = aborted_q;
`endif

  assign bus.busy     = busy;
  assign bus.done     = (state_q == S_FIN);
  assign bus.y3       = y_q[3];
  assign bus.y2       = y_q[2];
  assign bus.y1       = y_q[1];
  assign bus.y0       = y_q[0];
  assign bus.prog_err = err_q;

endmodule
